// File: rtl/fir_mac_par_if.sv
// fir_mac_par_if: start/memory/result bundle between the FIR MAC and its environment.
interface fir_mac_par_if #(
  parameter int NLANES = 4,
  parameter int DW = 18,
  parameter int CW = 36,
  parameter int OW = 18,
  parameter int AW = 10
);
  logic start;
  logic [NLANES*CW-1:0] coefs_in;
  logic [NLANES*DW-1:0] datain;
  logic [AW-1:0] addr_coefs;
  logic [AW-1:0] addr_data;
  logic busy;
  logic [OW-1:0] dataout;
  logic dataout_ready;
  logic ovf;
  modport master (
    output start, coefs_in, datain,
    input addr_coefs, addr_data, busy, dataout, dataout_ready, ovf
  );
  modport slave (
    input start, coefs_in, datain,
    output addr_coefs, addr_data, busy, dataout, dataout_ready, ovf
  );
endinterface

// File: rtl/fir_mac_par.sv
// fir_mac_par: NLANES-wide FIR MAC, registered lane adder tree, round-half-even output.
// Define FIR_MAC_SAT_EN to saturate out-of-range results instead of wrapping them.
module fir_mac_par #(
  parameter int NLANES = 4,
  parameter int NTAPS = 4096,
  parameter int DW = 18,
  parameter int CW = 36,
  parameter int FRAC = 35,
  parameter int OW = 18,
  parameter int AW = $clog2(NTAPS / NLANES)
) (
  input logic clock,
  input logic reset_n,
  fir_mac_par_if.slave bus
);
  localparam int N = NTAPS / NLANES;
  localparam int PW = DW + CW;
  localparam int ACW = PW + $clog2(N);
  localparam int TW = PW + $clog2(NTAPS);
  localparam int RW = TW - FRAC + 1;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  state_t state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic acc_en_q, acc_en_d, rdy_q, rdy_d, ovf_q, ovf_d;
  logic [2:0] pipe_q, pipe_d;
  logic signed [ACW-1:0] acc_q [NLANES];
  logic signed [ACW-1:0] acc_d [NLANES];
  logic signed [TW-1:0] tree_q, tree_d;
  logic signed [OW-1:0] dout_q, dout_d;
  logic signed [PW-1:0] prod [NLANES];
  logic signed [RW-1:0] fl, rnd;
  logic [FRAC-1:0] frac;
  logic go, wrap, up, ovf_c;
  logic [OW-1:0] res;
  always_comb begin
    go = state_q == IDLE && bus.start;
    wrap = state_q == RUN && addr_q == AW'(N - 1);
    state_d = go ? RUN : wrap ? DRAIN : (state_q == DRAIN && rdy_q) ? IDLE : state_q;
    addr_d = (state_q == RUN && !wrap) ? addr_q + AW'(1) : '0;
    // memory data arrives one cycle after its address; pipe tracks the last tap to the output
    acc_en_d = state_q == RUN;
    pipe_d = {pipe_q[1:0], wrap};
    rdy_d = pipe_q[2];
    tree_d = '0;
    for (int i = 0; i < NLANES; i++) begin
      prod[i] = PW'($signed(bus.datain[(NLANES-1-i)*DW +: DW])) * PW'($signed(bus.coefs_in[(NLANES-1-i)*CW +: CW]));
      acc_d[i] = go ? '0 : acc_en_q ? acc_q[i] + ACW'(prod[i]) : acc_q[i];
      tree_d = tree_d + TW'(acc_q[i]);
    end
    fl = RW'(tree_q >>> FRAC);
    frac = tree_q[FRAC-1:0];
    up = frac > {1'b1, {(FRAC-1){1'b0}}} || (frac == {1'b1, {(FRAC-1){1'b0}}} && fl[0]);
    rnd = fl + RW'(up);
    ovf_c = !(&rnd[RW-1:OW-1] || !(|rnd[RW-1:OW-1]));
`ifdef FIR_MAC_SAT_EN
    res = ovf_c ? {rnd[RW-1], {(OW-1){~rnd[RW-1]}}} : rnd[OW-1:0];
`else
    res = rnd[OW-1:0];
`endif
    dout_d = pipe_q[2] ? res : dout_q;
    ovf_d = pipe_q[2] ? ovf_c : ovf_q;
  end
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q <= IDLE;
      addr_q <= '0;
      acc_en_q <= 1'b0;
      pipe_q <= '0;
      rdy_q <= 1'b0;
      acc_q <= '{default: '0};
      tree_q <= '0;
      dout_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q <= addr_d;
      acc_en_q <= acc_en_d;
      pipe_q <= pipe_d;
      rdy_q <= rdy_d;
      acc_q <= acc_d;
      tree_q <= tree_d;
      dout_q <= dout_d;
      ovf_q <= ovf_d;
    end
  end
  assign bus.addr_coefs = addr_q;
  assign bus.addr_data = addr_q;
  assign bus.busy = state_q != IDLE;
  assign bus.dataout = dout_q;
  assign bus.dataout_ready = rdy_q;
  assign bus.ovf = ovf_q;
endmodule

// File: doc/fir_mac_par.md
FIR_MAC_PAR -- requirements
Module: fir_mac_par

Interface
REQ-001 SHALL have parameter NLANES, default 4: parallel MAC lanes (taps consumed per cycle).
REQ-002 SHALL have parameter NTAPS, default 4096: total taps; multiple of NLANES; N = NTAPS/NLANES.
REQ-003 SHALL have parameter DW, default 18: signed sample width.
REQ-004 SHALL have parameter CW, default 36: signed coefficient width.
REQ-005 SHALL have parameter FRAC, default 35: fractional bits of the coefficient, removed at output.
REQ-006 SHALL have parameter OW, default 18: signed output width.
REQ-007 SHALL have parameter AW, default clog2(N): memory address width.
REQ-008 SHALL have port clock  input  1  sole clock; all logic on rising edge.
REQ-009 SHALL have port reset_n  input  1  synchronous, active-low reset.
REQ-010 SHALL have port start  input  1  new-sample pulse; begins one output computation.
REQ-011 SHALL have port coefs_in  input  NLANES*CW  coefficients; lane 0 in the MS slice.
REQ-012 SHALL have port datain  input  NLANES*DW  samples; lane 0 (newest) in the MS slice.
REQ-013 SHALL have port addr_coefs  output  AW  coefficient memory address.
REQ-014 SHALL have port addr_data  output  AW  circular-buffer address.
REQ-015 SHALL have port busy  output  1  high from start acceptance until dataout_ready cycle inclusive.
REQ-016 SHALL have port dataout  output  OW  rounded result; held until next result.
REQ-017 SHALL have port dataout_ready  output  1  single-cycle pulse, result valid.
REQ-018 SHALL have port ovf  output  1  valid with dataout_ready; result exceeded OW signed range.

Function
REQ-019 SHALL implement FSM IDLE -> RUN -> DRAIN -> IDLE; start sampled only in IDLE.
REQ-020 SHALL on start in IDLE (edge E) clear all lane accumulators and move to RUN.
REQ-021 SHALL in RUN drive addr_coefs = addr_data = 0..N-1 on consecutive cycles after E, then enter DRAIN.
REQ-022 SHALL treat memories as 1-cycle synchronous read: data for address k is sampled one cycle after k is driven.
REQ-023 SHALL in each lane accumulate signed DW x CW products at full width DW+CW+clog2(N) with no intermediate truncation.
REQ-024 SHALL sum lanes via a registered adder tree of width DW+CW+clog2(NTAPS).
REQ-025 SHALL drop FRAC LSbits with round-to-nearest, ties-to-even.
REQ-026 SHALL assert dataout_ready for exactly one cycle, N+3 cycles after E, with dataout and ovf updated in that cycle.
REQ-027 SHALL ignore start while busy; no queuing, no effect on the running computation.
REQ-028 SHALL accept a start in the cycle immediately after dataout_ready (back-to-back).
REQ-029 SHALL set ovf when the rounded value lies outside [-2^(OW-1), 2^(OW-1)-1].
REQ-030 SHALL leave addresses at 0 when idle.

Reset
REQ-031 SHALL, with reset_n low at a rising edge, force IDLE, clear accumulators and the adder tree, and drive addr_coefs=0, addr_data=0, busy=0, dataout=0, dataout_ready=0, ovf=0.
REQ-032 SHALL abort any computation on mid-operation reset; no dataout_ready for the aborted sample.
REQ-033 SHALL give reset priority over start in the same cycle.

Configuration
REQ-034 SHALL, with FIR_MAC_SAT_EN defined, saturate out-of-range results to 2^(OW-1)-1 or -2^(OW-1).
REQ-035 SHALL, without FIR_MAC_SAT_EN, output the OW LSbits of the rounded value (two's-complement wrap); ovf is reported in both builds.

Verification (NLANES=4, NTAPS=16, N=4, defaults otherwise)
REQ-036 SHALL cover: all data=100, all coefs=2^34 (0.5), start -> dataout=800, ovf=0, ready exactly 7 cycles after start.
REQ-037 SHALL cover rounding: one tap coef=2^34, others 0; data=1 -> 0; data=3 -> 2; data=-3 -> -2.
REQ-038 SHALL cover overflow: all data=131071, all coefs=2^35-1 -> ovf=1; dataout=131071 with FIR_MAC_SAT_EN, wrapped LSbits without.
REQ-039 SHALL cover busy start: second start pulsed 2 cycles after the first -> one ready pulse only, result unchanged.
REQ-040 SHALL cover mid-op reset: reset_n low 3 cycles after start -> no ready, dataout=0; following start -> correct result at 7 cycles.
REQ-041 SHALL cover back-to-back: start in the cycle after ready -> second ready exactly 7 cycles later.
